program_loader: RTL and testbench

- Upstream boot stage for the 16-bit single-cycle CPU.
- Accepts a framed byte stream over a valid/ready handshake, assembles 16-bit instructions, and writes them into instruction memory starting at address 0.
- Holds the CPU in reset until a complete frame passes its checksum.
- Sits between the external byte source (UART or testbench) and the instruction-memory write port and CPU reset input.

---
 rtl/loader_pkg.sv | 25 ++
 rtl/byte_xor_acc.sv | 31 +++
 rtl/program_loader.sv | 187 ++++++++++++++++++
 tb/tb_program_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared states and error codes for the program loader
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CHK  = 2'b10;

    // States in which a stream byte can be consumed.
    function automatic logic is_rx_state(input state_t s);
        return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA_HI) ||
               (s == S_DATA_LO) || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/byte_xor_acc.sv
// rtl/byte_xor_acc.sv - 8-bit XOR accumulator with clear and enable
module byte_xor_acc (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] acc
);

    logic [7:0] acc_q;
    logic [7:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr)
            acc_d = 8'h00;
        else if (en)
            acc_d = acc_q ^ din;
    end

    always_ff @(posedge clk) begin
        if (reset)
            acc_q <= 8'h00;
        else
            acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte stream to instruction memory boot loader
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [15:0]       word_count
);

    localparam logic [16:0] MAX_W17 = 17'(MAX_WORDS);

    state_t            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        err_kind_q, err_kind_d;
    logic [15:0]       word_count_q, word_count_d;
    logic              in_ready_q, in_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [15:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;

    logic       accept;
    logic       acc_clr;
    logic       acc_en;
    logic [7:0] acc;

    assign accept = in_valid && in_ready_q;

    byte_xor_acc u_chk (
        .clk   (clk),
        .reset (reset),
        .clr   (acc_clr),
        .en    (acc_en),
        .din   (in_data),
        .acc   (acc)
    );

    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        hi_d         = hi_q;
        idx_d        = idx_q;
        err_kind_d   = err_kind_q;
        word_count_d = word_count_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        acc_clr      = 1'b0;
        acc_en       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_LEN_HI;
                    acc_clr    = 1'b1;
                    idx_d      = '0;
                    err_kind_d = ERR_NONE;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    acc_en   = 1'b1;
                    len_hi_d = in_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    acc_en       = 1'b1;
                    word_count_d = {len_hi_q, in_data};
                    if ({1'b0, word_count_d} > MAX_W17) begin
                        state_d    = S_ERROR;
                        err_kind_d = ERR_LEN;
                    end else if (word_count_d == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    acc_en  = 1'b1;
                    hi_d    = in_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    acc_en       = 1'b1;
                    imem_we_d    = 1'b1;
                    imem_addr_d  = idx_q;
                    imem_wdata_d = {hi_q, in_data};
                    idx_d        = idx_q + 1'b1;
                    // Compare in 16 bits so a full 2**ADDR_W program ends before the index wraps.
                    if (16'(idx_q) + 16'd1 == word_count_q)
                        state_d = S_CHECK;
                    else
                        state_d = S_DATA_HI;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    if (in_data == acc) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_ERROR;
                        err_kind_d = ERR_CHK;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // in_ready follows the next state so no byte is taken after leaving a receive state;
        // status flags follow the current state and so trail it by one cycle.
        in_ready_d  = is_rx_state(state_d);
        done_d      = (state_q == S_DONE);
        error_d     = (state_q == S_ERROR);
        cpu_reset_d = (state_q != S_DONE);
        err_code_d  = (state_q == S_ERROR) ? err_kind_q : ERR_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_hi_q     <= 8'h00;
            hi_q         <= 8'h00;
            idx_q        <= '0;
            err_kind_q   <= ERR_NONE;
            word_count_q <= 16'd0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 16'd0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            hi_q         <= hi_d;
            idx_q        <= idx_d;
            err_kind_q   <= err_kind_d;
            word_count_q <= word_count_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_code   = err_code_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [15:0] word_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;
    wr_t sb[$];

    program_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h:%0h required=none", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("write_addr", 32'(imem_addr), 32'(e.addr));
                chk("write_data", 32'(imem_wdata), 32'(e.data));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout actual=in_ready_low required=accept");
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'hxx;
    endtask

    // Sends a complete frame, queueing the writes it should cause.
    task automatic load(input logic [15:0] w[$], input bit bad_chk, input bit gappy, input bit mid_start);
        logic [7:0] bytes[$];
        logic [7:0] x;
        bytes.push_back(8'(w.size() >> 8));
        bytes.push_back(8'(w.size()));
        foreach (w[i]) begin
            bytes.push_back(w[i][15:8]);
            bytes.push_back(w[i][7:0]);
            sb.push_back('{addr: 8'(i), data: w[i]});
        end
        x = 8'h00;
        foreach (bytes[i]) x = x ^ bytes[i];
        bytes.push_back(bad_chk ? (x ^ 8'h13) : x);
        foreach (bytes[i]) begin
            send_byte(bytes[i], gappy ? int'($urandom_range(0, 3)) : 0);
            if (mid_start && i == 2) pulse_start();
        end
    endtask

    logic [15:0] prog1[$];

    initial begin
        prog1 = '{16'h1234, 16'hA0F1};
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_imem_we", 32'(imem_we), 0);
        chk("rst_cpu_reset", 32'(cpu_reset), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_word_count", 32'(word_count), 0);
        reset = 1'b0;

        // in_valid held with no start consumes nothing
        in_valid = 1'b1; in_data = 8'h55;
        repeat (3) @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 0);
        in_valid = 1'b0;

        // Scenario 1: normal load
        pulse_start();
        chk("s1_in_ready", 32'(in_ready), 1);
        load(prog1, 0, 0, 0);
        @(negedge clk);
        chk("s1_done", 32'(done), 1);
        chk("s1_cpu_reset", 32'(cpu_reset), 0);
        chk("s1_word_count", 32'(word_count), 2);
        chk("s1_sb_empty", 32'(sb.size()), 0);

        // Scenario 2: empty program, done two cycles after CHK
        pulse_start();
        load('{}, 0, 0, 0);
        chk("s2_done_early", 32'(done), 0);
        @(negedge clk);
        chk("s2_done", 32'(done), 1);
        chk("s2_word_count", 32'(word_count), 0);

        // Scenario 3: length too large
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        chk("s3_error", 32'(error), 1);
        chk("s3_err_code", 32'(err_code), 1);
        chk("s3_in_ready", 32'(in_ready), 0);
        chk("s3_cpu_reset", 32'(cpu_reset), 1);
        chk("s3_word_count", 32'(word_count), 16'h0101);

        // Scenario 4: bad checksum, then recovery
        pulse_start();
        load(prog1, 1, 0, 0);
        @(negedge clk);
        chk("s4_error", 32'(error), 1);
        chk("s4_err_code", 32'(err_code), 2);
        chk("s4_cpu_reset", 32'(cpu_reset), 1);
        chk("s4_done", 32'(done), 0);
        chk("s4_sb_empty", 32'(sb.size()), 0);
        pulse_start();
        load(prog1, 0, 0, 0);
        @(negedge clk);
        chk("s4b_done", 32'(done), 1);
        chk("s4b_err_code", 32'(err_code), 0);

        // Scenario 5: backpressure and start while busy
        pulse_start();
        load(prog1, 0, 1, 1);
        @(negedge clk);
        chk("s5_done", 32'(done), 1);
        chk("s5_cpu_reset", 32'(cpu_reset), 0);
        chk("s5_sb_empty", 32'(sb.size()), 0);

        // Scenario 6: reset mid-frame
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("s6_in_ready", 32'(in_ready), 0);
        chk("s6_imem_we", 32'(imem_we), 0);
        chk("s6_cpu_reset", 32'(cpu_reset), 1);
        chk("s6_done", 32'(done), 0);
        chk("s6_error", 32'(error), 0);
        chk("s6_err_code", 32'(err_code), 0);
        chk("s6_word_count", 32'(word_count), 0);
        chk("s6_imem_addr", 32'(imem_addr), 0);
        chk("s6_imem_wdata", 32'(imem_wdata), 0);
        repeat (2) @(negedge clk);
        pulse_start();
        load(prog1, 0, 0, 0);
        @(negedge clk);
        chk("s6b_done", 32'(done), 1);

        repeat (3) @(negedge clk);
        chk("final_sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
